// File: rtl/key_debouncer_if.sv
// Key channel bundle: raw pushbuttons in, debounced level and edge strobes out.
// The master drives the raw keys; the slave (the debouncer) drives the outputs.
interface key_debouncer_if #(
   parameter int NKEYS = 4
);
   logic [NKEYS-1:0] KEY_raw;
   logic [NKEYS-1:0] KEY_db;
   logic [NKEYS-1:0] press_pulse;
   logic [NKEYS-1:0] release_pulse;

   modport master (
      output KEY_raw,
      input  KEY_db,
      input  press_pulse,
      input  release_pulse
   );

   modport slave (
      input  KEY_raw,
      output KEY_db,
      output press_pulse,
      output release_pulse
   );
endinterface

// File: rtl/key_debouncer.sv
// Per-key synchroniser plus stable-interval qualifier for active-low pushbuttons.
// Produces a registered clean level and one-cycle press/release strobes.
module key_debouncer #(
   parameter int NKEYS       = 4,
   parameter int DB_CYCLES   = 1000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic            Clock,
   input  logic            Resetn,
   key_debouncer_if.slave  keys
);

   localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      REL     = 2'd0,
      WAIT_P  = 2'd1,
      PRESSED = 2'd2,
      WAIT_R  = 2'd3
   } state_t;

   genvar i;
   generate
      for (i = 0; i < NKEYS; i++) begin : g_chan
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   s;
         state_t                 state;
         state_t                 state_nxt;
         logic [CNT_W-1:0]       cnt;
         logic [CNT_W-1:0]       cnt_nxt;
         logic                   lvl;
         logic                   db_q;
         logic                   press_q;
         logic                   release_q;

         // Idle level is 1 (released), so the chain resets high to avoid a false press.
         always_ff @(posedge Clock) begin
            if (!Resetn) begin
               sync_q <= '1;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], keys.KEY_raw[i]};
            end
         end

         assign s = sync_q[SYNC_STAGES-1];

         always_ff @(posedge Clock) begin
            if (!Resetn) begin
               state <= REL;
               cnt   <= '0;
            end else begin
               state <= state_nxt;
               cnt   <= cnt_nxt;
            end
         end

         // Any sample at the old level during a WAIT state throws away the qualification run.
         always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
               REL: begin
                  if (!s) begin
                     state_nxt = WAIT_P;
                     cnt_nxt   = '0;
                  end
               end
               WAIT_P: begin
                  if (s) begin
                     state_nxt = REL;
                     cnt_nxt   = '0;
                  end else if (cnt == CNT_LAST) begin
                     state_nxt = PRESSED;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_ONE;
                  end
               end
               PRESSED: begin
                  if (s) begin
                     state_nxt = WAIT_R;
                     cnt_nxt   = '0;
                  end
               end
               WAIT_R: begin
                  if (!s) begin
                     state_nxt = PRESSED;
                     cnt_nxt   = '0;
                  end else if (cnt == CNT_LAST) begin
                     state_nxt = REL;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_ONE;
                  end
               end
               default: begin
                  state_nxt = REL;
                  cnt_nxt   = '0;
               end
            endcase
         end

         always_comb begin
            lvl = 1'b1;
            case (state)
               REL, WAIT_P:     lvl = 1'b1;
               PRESSED, WAIT_R: lvl = 1'b0;
               default:         lvl = 1'b1;
            endcase
         end

         // Strobes come from the same register stage as the level, so they line up exactly.
         always_ff @(posedge Clock) begin
            if (!Resetn) begin
               db_q      <= 1'b1;
               press_q   <= 1'b0;
               release_q <= 1'b0;
            end else begin
               db_q      <= lvl;
               press_q   <= db_q & ~lvl;
               release_q <= ~db_q & lvl;
            end
         end

         assign keys.KEY_db[i]        = db_q;
         assign keys.press_pulse[i]   = press_q;
         assign keys.release_pulse[i] = release_q;
      end
   endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios with literal expectations,
// then random bouncing keys and resets compared every cycle against a run-length model.
module tb_key_debouncer;

   localparam int NK = 4;
   localparam int DB = 4;
   localparam int SS = 2;

   logic Clock;
   logic Resetn;

   key_debouncer_if #(.NKEYS(NK)) kif ();

   key_debouncer #(
      .NKEYS(NK),
      .DB_CYCLES(DB),
      .SYNC_STAGES(SS)
   ) dut (
      .Clock(Clock),
      .Resetn(Resetn),
      .keys(kif.slave)
   );

   int checks = 0;
   int errors = 0;

   // Model: a key flips its internal level after DB+1 consecutive synchronised samples
   // at the opposite level; outputs show that level one register later.
   logic [SS-1:0] mSync [NK];
   int            mRun  [NK];
   logic [NK-1:0] mLvl;
   logic [NK-1:0] mDb;
   logic [NK-1:0] mPress;
   logic [NK-1:0] mRel;
   bit            modelValid = 0;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic checkOutput(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic modelStep();
      logic s;
      if (!Resetn) begin
         for (int k = 0; k < NK; k++) begin
            mSync[k] = '1;
            mRun[k]  = 0;
         end
         mLvl       = '1;
         mDb        = '1;
         mPress     = '0;
         mRel       = '0;
         modelValid = 1;
      end else begin
         mPress = mDb & ~mLvl;
         mRel   = ~mDb & mLvl;
         mDb    = mLvl;
         for (int k = 0; k < NK; k++) begin
            s = mSync[k][SS-1];
            if (s != mLvl[k]) begin
               mRun[k]++;
               if (mRun[k] == DB + 1) begin
                  mLvl[k] = s;
                  mRun[k] = 0;
               end
            end else begin
               mRun[k] = 0;
            end
            mSync[k] = {mSync[k][SS-2:0], kif.KEY_raw[k]};
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge Clock);
         modelStep();
      end
   end

   initial begin
      forever begin
         @(negedge Clock);
         if (modelValid) begin
            checkOutput("model_KEY_db", kif.KEY_db, mDb);
            checkOutput("model_press", kif.press_pulse, mPress);
            checkOutput("model_release", kif.release_pulse, mRel);
         end
      end
   end

   task automatic applyStimulus(input logic [NK-1:0] raw, input logic rstn, input int cycles);
      @(negedge Clock);
      kif.KEY_raw = raw;
      Resetn      = rstn;
      for (int c = 1; c < cycles; c++) @(negedge Clock);
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic checkAll(input string tag, input logic [NK-1:0] db, input logic [NK-1:0] pr,
                           input logic [NK-1:0] rl);
      checkOutput({tag, "_db"}, kif.KEY_db, db);
      checkOutput({tag, "_press"}, kif.press_pulse, pr);
      checkOutput({tag, "_release"}, kif.release_pulse, rl);
   endtask

   initial begin
      logic [NK-1:0] r;
      logic          rn;
      kif.KEY_raw = '1;
      Resetn      = 1'b0;

      applyStimulus(4'hF, 1'b0, 3);
      applyStimulus(4'hF, 1'b1, 50);
      #1;
      checkAll("t1_idle", 4'hF, 4'h0, 4'h0);

      applyStimulus(4'hE, 1'b1, 1);
      waitEdges(7);
      checkAll("t2_edge6", 4'hF, 4'h0, 4'h0);
      waitEdges(1);
      checkAll("t2_edge7", 4'hE, 4'h1, 4'h0);
      waitEdges(1);
      checkAll("t2_edge8", 4'hE, 4'h0, 4'h0);
      applyStimulus(4'hE, 1'b1, 10);

      applyStimulus(4'hC, 1'b1, 2);
      applyStimulus(4'hE, 1'b1, 2);
      applyStimulus(4'hC, 1'b1, 2);
      applyStimulus(4'hE, 1'b1, 2);
      applyStimulus(4'hC, 1'b1, 1);
      waitEdges(7);
      checkAll("t3_edge6", 4'hE, 4'h0, 4'h0);
      waitEdges(1);
      checkAll("t3_edge7", 4'hC, 4'h2, 4'h0);
      applyStimulus(4'hC, 1'b1, 10);

      applyStimulus(4'hD, 1'b1, 1);
      waitEdges(7);
      checkAll("t4_edge6", 4'hC, 4'h0, 4'h0);
      waitEdges(1);
      checkAll("t4_edge7", 4'hD, 4'h0, 4'h1);
      waitEdges(1);
      checkAll("t4_edge8", 4'hD, 4'h0, 4'h0);
      applyStimulus(4'hD, 1'b1, 10);

      applyStimulus(4'h1, 1'b1, 1);
      waitEdges(8);
      checkAll("t5_edge7", 4'h1, 4'hC, 4'h0);
      applyStimulus(4'hF, 1'b1, 20);

      applyStimulus(4'hE, 1'b1, 1);
      waitEdges(5);
      applyStimulus(4'hE, 1'b0, 1);
      waitEdges(1);
      checkAll("t6_inreset", 4'hF, 4'h0, 4'h0);
      applyStimulus(4'hE, 1'b0, 2);
      applyStimulus(4'hE, 1'b1, 1);
      waitEdges(7);
      checkAll("t6_edge6", 4'hF, 4'h0, 4'h0);
      waitEdges(1);
      checkAll("t6_edge7", 4'hE, 4'h1, 4'h0);
      applyStimulus(4'hF, 1'b1, 20);

      r = 4'hF;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NK; k++) begin
            if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
         end
         rn = ($urandom_range(0, 299) != 0);
         applyStimulus(r, rn, 1);
      end
      applyStimulus(4'hF, 1'b1, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
